// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-ported memory between instruction fetch and data access.
// Data has priority, a fairness counter bounds fetch starvation, a watchdog aborts hung accesses.
module mem_port_arbiter #(
  parameter int unsigned DATA_MAX = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  // fetch stage
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic [31:0] instr_rdata,
  // memory stage
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wmask,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  // memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam int unsigned FairW = $clog2(DATA_MAX + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

  localparam logic [FairW-1:0] FairMax = FairW'(DATA_MAX);
  localparam logic [TmoW-1:0]  TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD,
    StResp
  } state_e;

  state_e             state_q;
  logic [FairW-1:0]   fair_cnt_q;
  logic [TmoW-1:0]    tmo_cnt_q;
  logic               abort_q;

  logic grant_i;
  logic grant_d;
  logic busy;
  logic tmo_hit;
  logic fetch_aborted;
  logic finish;

  // Arbitration is only meaningful in IDLE; the fairness cap forces a fetch grant.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == StIdle) begin
      if (data_req && instr_req && (fair_cnt_q == FairMax)) begin
        grant_i = 1'b1;
      end else if (data_req) begin
        grant_d = 1'b1;
      end else if (instr_req) begin
        grant_i = 1'b1;
      end
    end
  end

  always_comb begin
    busy          = (state_q == StBusyI) || (state_q == StBusyD);
    tmo_hit       = (tmo_cnt_q == TmoLast);
    finish        = busy && (mem_ack || tmo_hit);
    // Includes a drop sampled on the very edge that completes the access.
    fetch_aborted = abort_q || ((state_q == StBusyI) && !instr_req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      fair_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      abort_q     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
      instr_ack   <= 1'b0;
      instr_rdata <= '0;
      data_ack    <= 1'b0;
      data_rdata  <= '0;
      bus_err     <= 1'b0;
    end else begin
      instr_ack <= 1'b0;
      data_ack  <= 1'b0;
      bus_err   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (grant_i) begin
            state_q    <= StBusyI;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= instr_addr;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            tmo_cnt_q  <= '0;
            fair_cnt_q <= '0;
          end else if (grant_d) begin
            state_q   <= StBusyD;
            mem_req   <= 1'b1;
            mem_we    <= data_wr;
            mem_addr  <= data_addr;
            mem_wdata <= data_wdata;
            mem_wmask <= data_wr ? data_wmask : 4'b0000;
            tmo_cnt_q <= '0;
            if (!instr_req) begin
              fair_cnt_q <= '0;
            end else if (fair_cnt_q != FairMax) begin
              fair_cnt_q <= fair_cnt_q + 1'b1;
            end
          end
        end

        StBusyI, StBusyD: begin
          if ((state_q == StBusyI) && !instr_req) begin
            abort_q <= 1'b1;
          end
          if (finish) begin
            // Acks are registered here so they are visible during the RESP cycle;
            // mem_ack takes precedence over a coincident timeout.
            state_q <= StResp;
            mem_req <= 1'b0;
            if (state_q == StBusyD) begin
              data_ack   <= 1'b1;
              data_rdata <= mem_ack ? mem_rdata : 32'h0;
              bus_err    <= !mem_ack;
            end else if (!fetch_aborted) begin
              instr_ack   <= 1'b1;
              instr_rdata <= mem_ack ? mem_rdata : 32'h0;
              bus_err     <= !mem_ack;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        StResp: begin
          state_q <= StIdle;
          abort_q <= 1'b0;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, fairness, timeout, abort and reset cases.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_ack;
  logic [31:0] instr_rdata;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wmask;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(
    .DATA_MAX(4),
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_ack  (instr_ack),
    .instr_rdata(instr_rdata),
    .data_req   (data_req),
    .data_wr    (data_wr),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_wmask (data_wmask),
    .data_ack   (data_ack),
    .data_rdata (data_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wmask"}, mem_wmask, 0);
    chk({tag, "_instr_ack"}, instr_ack, 0);
    chk({tag, "_data_ack"}, data_ack, 0);
    chk({tag, "_instr_rdata"}, instr_rdata, 0);
    chk({tag, "_data_rdata"}, data_rdata, 0);
    chk({tag, "_bus_err"}, bus_err, 0);
  endtask

  initial begin
    logic is_i;
    rst        = 1'b1;
    instr_req  = 1'b0;
    instr_addr = '0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
    data_wmask = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;

    tick;
    tick;
    chk_all_zero("reset");
    rst = 1'b0;
    tick;

    // Single fetch, memory acks in the second BUSY cycle.
    instr_req  = 1'b1;
    instr_addr = 32'h100;
    tick;
    chk("fetch_req", mem_req, 1);
    chk("fetch_addr", mem_addr, 32'h100);
    chk("fetch_we", mem_we, 0);
    chk("fetch_wmask", mem_wmask, 0);
    tick;
    chk("fetch_req_hold", mem_req, 1);
    chk("fetch_no_early_ack", instr_ack, 0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0013;
    tick;
    mem_ack   = 1'b0;
    instr_req = 1'b0;
    chk("fetch_ack", instr_ack, 1);
    chk("fetch_rdata", instr_rdata, 32'h0000_0013);
    chk("fetch_no_dack", data_ack, 0);
    chk("fetch_req_drop", mem_req, 0);
    chk("fetch_no_err", bus_err, 0);
    tick;
    chk("fetch_ack_pulse", instr_ack, 0);
    chk("fetch_rdata_hold", instr_rdata, 32'h0000_0013);

    // Store, immediate ack in the first BUSY cycle.
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_addr  = 32'h2004;
    data_wdata = 32'hDEAD_BEEF;
    data_wmask = 4'b0011;
    tick;
    chk("store_req", mem_req, 1);
    chk("store_we", mem_we, 1);
    chk("store_addr", mem_addr, 32'h2004);
    chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("store_wmask", mem_wmask, 4'b0011);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0;
    tick;
    mem_ack  = 1'b0;
    data_req = 1'b0;
    data_wr  = 1'b0;
    chk("store_ack", data_ack, 1);
    chk("store_no_iack", instr_ack, 0);
    tick;
    chk("store_ack_pulse", data_ack, 0);

    // Continuous contention: D,D,D,D,I,D,D,D,D,I.
    instr_req  = 1'b1;
    instr_addr = 32'h100;
    data_req   = 1'b1;
    data_addr  = 32'h2000;
    for (int i = 0; i < 10; i++) begin
      is_i = (i == 4) || (i == 9);
      tick;
      chk("cont_req", mem_req, 1);
      chk("cont_addr", mem_addr, is_i ? 32'h100 : 32'h2000);
      mem_ack   = 1'b1;
      mem_rdata = 32'hA5A5_0000 + 32'(i);
      tick;
      mem_ack = 1'b0;
      chk("cont_iack", instr_ack, is_i);
      chk("cont_dack", data_ack, !is_i);
      tick;
    end
    instr_req = 1'b0;
    data_req  = 1'b0;
    chk("cont_last_irdata", instr_rdata, 32'hA5A5_0009);
    chk("cont_last_drdata", data_rdata, 32'hA5A5_0008);

    // Timeout on a data load: 8 BUSY cycles, then error response.
    data_req  = 1'b1;
    data_addr = 32'h3000;
    tick;
    for (int k = 0; k < 8; k++) begin
      chk("tmo_req_held", mem_req, 1);
      chk("tmo_no_ack", data_ack, 0);
      tick;
    end
    data_req = 1'b0;
    chk("tmo_req_drop", mem_req, 0);
    chk("tmo_dack", data_ack, 1);
    chk("tmo_err", bus_err, 1);
    chk("tmo_rdata", data_rdata, 32'h0);
    chk("tmo_no_iack", instr_ack, 0);
    tick;
    chk("tmo_err_pulse", bus_err, 0);

    // mem_ack in the same cycle the timeout would fire: ack wins.
    data_req  = 1'b1;
    data_addr = 32'h3004;
    tick;
    for (int k = 0; k < 7; k++) tick;
    chk("race_req", mem_req, 1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_1234;
    tick;
    mem_ack  = 1'b0;
    data_req = 1'b0;
    chk("race_dack", data_ack, 1);
    chk("race_no_err", bus_err, 0);
    chk("race_rdata", data_rdata, 32'h0000_1234);
    tick;

    // Fetch abort: instr_req drops in the second BUSY_I cycle.
    instr_req  = 1'b1;
    instr_addr = 32'h200;
    tick;
    chk("abort_req", mem_req, 1);
    tick;
    instr_req = 1'b0;
    tick;
    chk("abort_req_still", mem_req, 1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0BAD;
    tick;
    mem_ack = 1'b0;
    chk("abort_no_iack", instr_ack, 0);
    chk("abort_no_err", bus_err, 0);
    chk("abort_rdata_hold", instr_rdata, 32'hA5A5_0009);
    chk("abort_req_drop", mem_req, 0);
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h4000;
    tick;
    chk("abort_idle", mem_req, 0);
    tick;
    chk("post_abort_req", mem_req, 1);
    chk("post_abort_addr", mem_addr, 32'h4000);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0077;
    tick;
    mem_ack  = 1'b0;
    data_req = 1'b0;
    chk("post_abort_dack", data_ack, 1);
    chk("post_abort_rdata", data_rdata, 32'h0000_0077);
    tick;

    // Reset during BUSY_D drops the access silently.
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_addr  = 32'h5000;
    data_wdata = 32'h1122_3344;
    data_wmask = 4'b1111;
    tick;
    chk("rst_mid_busy", mem_req, 1);
    rst = 1'b1;
    tick;
    rst      = 1'b0;
    data_req = 1'b0;
    data_wr  = 1'b0;
    chk_all_zero("rst_mid");
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("rst_no_dack", data_ack, 0);
      chk("rst_no_req", mem_req, 0);
    end

    // Back in IDLE: a fresh fetch is granted after one edge.
    instr_req  = 1'b1;
    instr_addr = 32'h600;
    tick;
    chk("post_rst_req", mem_req, 1);
    chk("post_rst_addr", mem_addr, 32'h600);
    chk("post_rst_we", mem_we, 0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick;
    mem_ack   = 1'b0;
    instr_req = 1'b0;
    chk("post_rst_iack", instr_ack, 1);
    chk("post_rst_irdata", instr_rdata, 32'hCAFE_F00D);
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Accepts one transaction at a time and forwards it to the memory port. It returns the read data and acknowledge to the requester that owns the transaction.
- Data requests have priority. A fairness counter prevents fetch starvation, and a watchdog aborts hung memory transactions.

Parameters:
- DATA_MAX, 4: max consecutive data grants while instr_req is pending before fetch is forced a grant (>=1).
- TIMEOUT, 255: cycles to wait for mem_ack before aborting (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_req  in  1  fetch requests an instruction read
- instr_addr  in  32  fetch address
- instr_ack  out  1  one-cycle pulse: instr_rdata valid
- instr_rdata  out  32  instruction word
- data_req  in  1  data access request
- data_wr  in  1  1=store, 0=load
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_wmask  in  4  byte enables for stores
- data_ack  out  1  one-cycle pulse: access done / data_rdata valid
- data_rdata  out  32  load data
- mem_req  out  1  memory request, held until mem_ack or timeout
- mem_we  out  1  write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  write data
- mem_wmask  out  4  byte enables (4'b0000 on reads)
- mem_ack  in  1  memory completion, valid only while mem_req=1
- mem_rdata  in  32  memory read data, valid with mem_ack
- bus_err  out  1  one-cycle pulse, coincident with the aborted requester's ack, on timeout

Behaviour:
- Reset (synchronous):
  - State=IDLE.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, instr_ack, data_ack, instr_rdata, data_rdata, bus_err.
  - Fairness counter, timeout counter and abort flag cleared.
  - Reset mid-transaction drops the transaction silently; no ack is issued.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, arbitration sampled at the clock edge:
  - If data_req and instr_req are both set and fair_cnt==DATA_MAX, grant instr.
  - Otherwise, if data_req is set, grant data.
  - Otherwise, if instr_req is set, grant instr.
  - Otherwise stay in IDLE.
- On grant:
  - Register address, we, wdata, wmask into the mem_* outputs and set mem_req=1.
  - Go to BUSY_I or BUSY_D. Clear the timeout counter.
  - Instruction grants drive mem_we=0 and mem_wmask=0.
- Fairness counter:
  - Increments on each data grant made while instr_req=1, saturating at DATA_MAX.
  - Clears on any instr grant, and on a data grant with instr_req=0.
- BUSY_x:
  - mem_* outputs stay stable while mem_req=1. The timeout counter increments each cycle.
  - If mem_ack=1, capture mem_rdata, drop mem_req, go to RESP. mem_ack may arrive in the first BUSY cycle.
  - If the counter reaches TIMEOUT with no mem_ack, drop mem_req, force read data to 0, set the error flag, go to RESP.
- RESP, one cycle:
  - Pulse the owner's ack with rdata. Pulse bus_err if the error flag is set.
  - Return to IDLE. A new grant is evaluated in the next IDLE cycle, so back-to-back throughput is 1 transaction per 3 cycles minimum.
- Latency: request seen at edge N gives mem_req high in cycle N+1. With mem_ack in cycle N+1, the ack is in cycle N+2.
- Requesters hold req and payload stable until their ack. The arbiter samples the payload only at grant.
- Fetch abort (flush/PC change):
  - If instr_req drops while in BUSY_I, set the abort flag.
  - The memory transaction still completes or times out, but instr_ack and bus_err are suppressed in RESP.
  - The abort flag clears on leaving RESP.
  - Data requests must not drop before data_ack; behaviour is undefined if they do.
- Simultaneous events:
  - mem_ack in the same cycle the timeout counter reaches TIMEOUT: mem_ack wins, no bus_err.
  - instr_req re-asserted before RESP of an aborted transaction: abort is still honoured, and the new request is arbitrated fresh from IDLE.
- instr_ack and data_ack are never high in the same cycle.
- rdata outputs hold their last value between acks.

Test Plan:
- Single fetch: instr_req=1, addr=0x100, memory acks one cycle after mem_req rises with 0x00000013 -> mem_req high, mem_addr=0x100, mem_we=0; instr_ack pulse one cycle after mem_ack with instr_rdata=0x00000013.
- Store: data_req=1, wr=1, addr=0x2004, wdata=0xDEADBEEF, wmask=4'b0011 -> mem_we=1 and mem_* match; data_ack pulse; instr_ack stays 0.
- Contention fairness: instr_req and data_req held high continuously, DATA_MAX=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; no instr starvation.
- Timeout: memory never acks on a data load, TIMEOUT=8 -> mem_req drops after 8 BUSY cycles; data_ack=1, bus_err=1, data_rdata=0 in the same cycle.
- Fetch abort: instr_req dropped in the second BUSY_I cycle, mem_ack arrives later -> no instr_ack, no bus_err; a subsequent data_req is granted from IDLE normally.
- Reset mid-transaction: rst=1 during BUSY_D -> next cycle all outputs 0 and state IDLE; no ack ever issued for the dropped access.
